// File: rtl/prbs_bert_ctrl_if.sv
// Bus between the PRBS bit-error-rate controller and whatever drives and observes it.
// The master side drives the run control and the checker's error flags.
// The slave side (the controller) returns the checker controls, the state and the result counters.
interface prbs_bert_ctrl_if #(
    parameter int NBITS = 16,
    parameter int CNT_W = 32
);
    logic             START;
    logic             STOP;
    logic [CNT_W-1:0] WIN_LEN;
    logic [NBITS-1:0] ERR_VEC;
    logic             ERR_VLD;
    logic             PRBS_RST;
    logic             PRBS_EN;
    logic [2:0]       STATE;
    logic             LOCKED;
    logic             DONE;
    logic             SYNC_FAIL;
    logic             SYNC_LOST;
    logic [CNT_W-1:0] WORD_CNT;
    logic [CNT_W-1:0] ERR_CNT;

    modport master (
        output START, STOP, WIN_LEN, ERR_VEC, ERR_VLD,
        input  PRBS_RST, PRBS_EN, STATE, LOCKED, DONE, SYNC_FAIL, SYNC_LOST, WORD_CNT, ERR_CNT
    );

    modport slave (
        input  START, STOP, WIN_LEN, ERR_VEC, ERR_VLD,
        output PRBS_RST, PRBS_EN, STATE, LOCKED, DONE, SYNC_FAIL, SYNC_LOST, WORD_CNT, ERR_CNT
    );
endinterface

// File: rtl/prbs_bert_ctrl.sv
// PRBS bit-error-rate test controller.
// A run is IDLE -> ARM -> SYNC -> LOCKED -> DONE -> IDLE. SYNC waits for a clean run of words
// and gives up after a bounded number of words. LOCKED counts words and errored bits over the window.
// Every output comes straight from a flop; the status flops are loaded from the next-state value.
module prbs_bert_ctrl #(
    parameter int NBITS      = 16,
    parameter int SYNC_WORDS = 4,
    parameter int SYNC_TMO   = 1024,
    parameter int LOSS_THR   = 4,
    parameter int CNT_W      = 32
) (
    input logic               CLK,
    input logic               RST_N,
    prbs_bert_ctrl_if.slave   bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_SYNC   = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int CLEAN_W = $clog2(SYNC_WORDS + 1);
    localparam int TMO_W   = $clog2(SYNC_TMO + 1);
    // Wide enough that counter + popcount can never overflow before saturation is applied
    localparam int SUM_W   = CNT_W + $clog2(NBITS + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   win_len_q, win_len_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CLEAN_W-1:0] clean_cnt_q, clean_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               sync_fail_q, sync_fail_d;
    logic               sync_lost_q, sync_lost_d;
    logic               prbs_rst_q, prbs_rst_d;
    logic               prbs_en_q, prbs_en_d;
    logic               locked_q, locked_d;
    logic               done_q, done_d;

    logic [SUM_W-1:0]   pop;
    logic [SUM_W-1:0]   word_sum;
    logic [SUM_W-1:0]   err_sum;
    logic [CNT_W-1:0]   word_sat;
    logic [CNT_W-1:0]   err_sat;
    logic               heavy;

    // Next-state, counter and flag logic for one run; STOP outranks every other transition
    always_comb begin
        state_d     = state_q;
        win_len_d   = win_len_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        clean_cnt_d = clean_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        sync_fail_d = sync_fail_q;
        sync_lost_d = sync_lost_q;

        pop = '0;
        for (int i = 0; i < NBITS; i++) begin
            pop = pop + SUM_W'(bus.ERR_VEC[i]);
        end
        word_sum = SUM_W'(word_cnt_q) + SUM_W'(1);
        err_sum  = SUM_W'(err_cnt_q) + pop;
        word_sat = (word_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : word_sum[CNT_W-1:0];
        err_sat  = (err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
        heavy    = (pop >= SUM_W'(LOSS_THR));

        case (state_q)
            ST_IDLE: begin
                if (bus.START && !bus.STOP) begin
                    state_d     = ST_ARM;
                    win_len_d   = bus.WIN_LEN;
                    word_cnt_d  = '0;
                    err_cnt_d   = '0;
                    sync_fail_d = 1'b0;
                    sync_lost_d = 1'b0;
                end
            end
            ST_ARM: begin
                clean_cnt_d = '0;
                tmo_cnt_d   = '0;
                state_d     = bus.STOP ? ST_DONE : ST_SYNC;
            end
            ST_SYNC: begin
                if (bus.STOP) begin
                    state_d = ST_DONE;
                end else if (bus.ERR_VLD) begin
                    tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
                    clean_cnt_d = (bus.ERR_VEC == '0) ? clean_cnt_q + CLEAN_W'(1) : '0;
                    if (clean_cnt_d == CLEAN_W'(SYNC_WORDS)) begin
                        state_d = ST_LOCKED;
                    end else if (tmo_cnt_d == TMO_W'(SYNC_TMO)) begin
                        sync_fail_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.ERR_VLD) begin
                    word_cnt_d = word_sat;
                    err_cnt_d  = err_sat;
                    if (heavy) begin
                        sync_lost_d = 1'b1;
                    end
                end
                if (bus.STOP) begin
                    state_d = ST_DONE;
                end else if (bus.ERR_VLD && (win_len_q != '0) && (word_cnt_d == win_len_q)) begin
                    state_d = ST_DONE;
                end else if (bus.ERR_VLD && heavy) begin
                    state_d     = ST_SYNC;
                    clean_cnt_d = '0;
                    tmo_cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        prbs_rst_d = (state_d == ST_ARM);
        prbs_en_d  = (state_d == ST_SYNC) || (state_d == ST_LOCKED);
        locked_d   = (state_d == ST_LOCKED);
        done_d     = (state_d == ST_DONE);
    end

    // State, counters and registered outputs, cleared asynchronously by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            win_len_q   <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            clean_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            sync_fail_q <= 1'b0;
            sync_lost_q <= 1'b0;
            prbs_rst_q  <= 1'b0;
            prbs_en_q   <= 1'b0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_len_q   <= win_len_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            clean_cnt_q <= clean_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            sync_fail_q <= sync_fail_d;
            sync_lost_q <= sync_lost_d;
            prbs_rst_q  <= prbs_rst_d;
            prbs_en_q   <= prbs_en_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
        end
    end

    assign bus.STATE     = state_q;
    assign bus.PRBS_RST  = prbs_rst_q;
    assign bus.PRBS_EN   = prbs_en_q;
    assign bus.LOCKED    = locked_q;
    assign bus.DONE      = done_q;
    assign bus.SYNC_FAIL = sync_fail_q;
    assign bus.SYNC_LOST = sync_lost_q;
    assign bus.WORD_CNT  = word_cnt_q;
    assign bus.ERR_CNT   = err_cnt_q;
endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Testbench for the PRBS bit-error-rate controller.
// A default-parameter instance is exercised by a vector table, directed sequences and random
// traffic against a run-level reference model; a narrow-counter instance exercises saturation.
module tb_prbs_bert_ctrl;
    localparam int     NBITS      = 16;
    localparam int     CNT_W      = 32;
    localparam int     SYNC_WORDS = 4;
    localparam int     SYNC_TMO   = 1024;
    localparam int     LOSS_THR   = 4;
    localparam longint CNT_MAX    = (longint'(1) << CNT_W) - 1;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    int checks   = 0;
    int failures = 0;

    prbs_bert_ctrl_if #(.NBITS(NBITS), .CNT_W(CNT_W)) bus();
    prbs_bert_ctrl_if #(.NBITS(NBITS), .CNT_W(4))     sbus();

    prbs_bert_ctrl #(
        .NBITS(NBITS), .SYNC_WORDS(SYNC_WORDS), .SYNC_TMO(SYNC_TMO),
        .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus)
    );

    // Narrow counters and an unreachable loss threshold so heavy words stay in LOCKED
    prbs_bert_ctrl #(
        .NBITS(NBITS), .SYNC_WORDS(4), .SYNC_TMO(1024), .LOSS_THR(17), .CNT_W(4)
    ) sdut (
        .CLK(CLK), .RST_N(RST_N), .bus(sbus)
    );

    // Free-running 10 ns clock
    always #5 CLK = ~CLK;

    // Reference model: run phase, latched window, result counts and sync bookkeeping
    int     m_state;
    longint m_win, m_word, m_err, m_clean, m_tmo;
    bit     m_fail, m_lost;

    typedef struct {
        bit          start;
        bit          stop;
        bit          vld;
        logic [15:0] vec;
        logic [31:0] win;
        logic [2:0]  exp_state;
        bit          exp_rst;
        bit          exp_en;
        bit          exp_done;
        logic [31:0] exp_word;
        logic [31:0] exp_err;
    } vec_t;

    vec_t tbl[20];

    task automatic modelReset();
        m_state = 0; m_win = 0; m_word = 0; m_err = 0;
        m_clean = 0; m_tmo = 0; m_fail = 0; m_lost = 0;
    endtask

    task automatic modelStep(input bit start, input bit stop, input bit vld,
                             input logic [15:0] vec, input logic [31:0] win);
        int  ones;
        bit  lost;
        ones = $countones(vec);
        lost = 0;
        case (m_state)
            0: if (start && !stop) begin
                m_state = 1; m_win = longint'(win);
                m_word = 0; m_err = 0; m_fail = 0; m_lost = 0;
            end
            1: begin
                m_clean = 0; m_tmo = 0;
                m_state = stop ? 4 : 2;
            end
            2: if (stop) m_state = 4;
               else if (vld) begin
                   m_tmo++;
                   m_clean = (vec == 0) ? m_clean + 1 : 0;
                   if (m_clean == SYNC_WORDS) m_state = 3;
                   else if (m_tmo == SYNC_TMO) begin m_fail = 1; m_state = 4; end
               end
            3: begin
                if (vld) begin
                    m_word = (m_word + 1 > CNT_MAX) ? CNT_MAX : m_word + 1;
                    m_err  = (m_err + ones > CNT_MAX) ? CNT_MAX : m_err + ones;
                    lost   = (ones >= LOSS_THR);
                    if (lost) m_lost = 1;
                end
                if (stop) m_state = 4;
                else if (vld && m_win != 0 && m_word == m_win) m_state = 4;
                else if (vld && lost) begin m_state = 2; m_clean = 0; m_tmo = 0; end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] packActual();
        return {7'd0, bus.STATE, bus.PRBS_RST, bus.PRBS_EN, bus.LOCKED, bus.DONE,
                bus.SYNC_FAIL, bus.SYNC_LOST, bus.WORD_CNT, bus.ERR_CNT};
    endfunction

    function automatic logic [79:0] packModel();
        return {7'd0, 3'(m_state), m_state == 1, (m_state == 2) || (m_state == 3), m_state == 3,
                m_state == 4, m_fail, m_lost, 32'(m_word), 32'(m_err)};
    endfunction

    task automatic checkModel(input string name);
        checkOutput(name, packActual(), packModel());
    endtask

    // One clock of stimulus: drive after the falling edge, sample 1 ns after the rising edge
    task automatic applyStimulus(input bit start, input bit stop, input bit vld,
                                 input logic [15:0] vec, input logic [31:0] win);
        @(negedge CLK);
        bus.START = start; bus.STOP = stop; bus.ERR_VLD = vld;
        bus.ERR_VEC = vec; bus.WIN_LEN = win;
        @(posedge CLK);
        #1;
        modelStep(start, stop, vld, vec, win);
    endtask

    task automatic stepCheck(input bit start, input bit stop, input bit vld,
                             input logic [15:0] vec, input logic [31:0] win, input string name);
        applyStimulus(start, stop, vld, vec, win);
        checkModel(name);
    endtask

    task automatic runToLock(input logic [31:0] win);
        stepCheck(1, 0, 0, 16'h0, win, "arm");
        stepCheck(0, 0, 0, 16'h0, 0, "sync_entry");
        for (int i = 0; i < 4; i++) stepCheck(0, 0, 1, 16'h0, 0, "sync_clean");
        checkOutput("lock_reached", 80'(bus.STATE), 80'(3));
    endtask

    // Narrow instance: drive its bus, then advance one clock with the main DUT idle
    task automatic smallStep(input bit start, input bit stop, input bit vld,
                             input logic [15:0] vec);
        sbus.START = start; sbus.STOP = stop; sbus.ERR_VLD = vld;
        sbus.ERR_VEC = vec; sbus.WIN_LEN = 4'd0;
        applyStimulus(0, 0, 0, 16'h0, 0);
    endtask

    function automatic vec_t makeVec(bit start, bit vld, logic [15:0] vec, logic [31:0] win,
                                     logic [2:0] st, logic [31:0] word);
        vec_t v;
        v.start = start; v.stop = 0; v.vld = vld; v.vec = vec; v.win = win;
        v.exp_state = st;
        v.exp_rst   = (st == 3'd1);
        v.exp_en    = (st == 3'd2) || (st == 3'd3);
        v.exp_done  = (st == 3'd4);
        v.exp_word  = word;
        v.exp_err   = 0;
        return v;
    endfunction

    // Main test sequence
    initial begin
        logic [15:0] rvec;
        int          r;

        // Window run: 3 dirty words, 4 clean to lock, 10 locked words to finish
        tbl[0] = makeVec(1, 0, 16'h0000, 10, 3'd1, 0);
        tbl[1] = makeVec(0, 0, 16'h0000, 0, 3'd2, 0);
        for (int i = 2; i < 5; i++) tbl[i] = makeVec(0, 1, 16'hFFFF, 0, 3'd2, 0);
        for (int i = 5; i < 8; i++) tbl[i] = makeVec(0, 1, 16'h0000, 0, 3'd2, 0);
        tbl[8] = makeVec(0, 1, 16'h0000, 0, 3'd3, 0);
        for (int i = 9; i < 18; i++) tbl[i] = makeVec(0, 1, 16'h0000, 0, 3'd3, 32'(i - 8));
        tbl[18] = makeVec(0, 1, 16'h0000, 0, 3'd4, 10);
        tbl[19] = makeVec(0, 0, 16'h0000, 0, 3'd0, 10);

        bus.START = 0; bus.STOP = 0; bus.ERR_VLD = 0; bus.ERR_VEC = '0; bus.WIN_LEN = '0;
        sbus.START = 0; sbus.STOP = 0; sbus.ERR_VLD = 0; sbus.ERR_VEC = '0; sbus.WIN_LEN = '0;
        modelReset();
        #12;
        checkOutput("reset_state", packActual(), 80'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        stepCheck(0, 0, 0, 16'h0, 0, "post_reset_idle");

        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].start, tbl[i].stop, tbl[i].vld, tbl[i].vec, tbl[i].win);
            checkOutput($sformatf("window_run[%0d]", i),
                        {10'd0, bus.STATE, bus.PRBS_RST, bus.PRBS_EN, bus.DONE, bus.WORD_CNT, bus.ERR_CNT},
                        {10'd0, tbl[i].exp_state, tbl[i].exp_rst, tbl[i].exp_en, tbl[i].exp_done,
                         tbl[i].exp_word, tbl[i].exp_err});
        end

        // Error counting over an 8-word window
        runToLock(8);
        for (int w = 1; w <= 8; w++)
            stepCheck(0, 0, 1, (w == 2 || w == 5) ? 16'h0003 : 16'h0000, 0, "err_window");
        checkOutput("err_window_end",
                    {bus.STATE, bus.DONE, bus.SYNC_LOST, bus.WORD_CNT, bus.ERR_CNT},
                    {3'd4, 1'b1, 1'b0, 32'd8, 32'd4});
        stepCheck(0, 0, 0, 16'h0, 0, "err_window_idle");

        // Loss of lock, relock, then abort with a word in the same cycle
        runToLock(0);
        for (int w = 0; w < 3; w++) stepCheck(0, 0, 1, 16'h0000, 0, "pre_loss");
        stepCheck(0, 0, 1, 16'h000F, 0, "loss_word");
        checkOutput("loss_result", {bus.STATE, bus.SYNC_LOST, bus.WORD_CNT, bus.ERR_CNT},
                    {3'd2, 1'b1, 32'd4, 32'd4});
        stepCheck(0, 0, 1, 16'h0000, 0, "relock_1");
        stepCheck(0, 0, 0, 16'h0000, 0, "relock_gap");
        stepCheck(0, 0, 1, 16'h0000, 0, "relock_2");
        stepCheck(0, 0, 1, 16'h0000, 0, "relock_3");
        checkOutput("relock_pending", 80'(bus.STATE), 80'(2));
        stepCheck(0, 0, 1, 16'h0000, 0, "relock_4");
        checkOutput("relocked", {bus.STATE, bus.LOCKED, bus.WORD_CNT}, {3'd3, 1'b1, 32'd4});
        stepCheck(0, 0, 1, 16'h0000, 0, "relocked_word");
        stepCheck(0, 1, 1, 16'h0001, 0, "stop_locked");
        checkOutput("stop_done", {bus.STATE, bus.DONE, bus.WORD_CNT, bus.ERR_CNT},
                    {3'd4, 1'b1, 32'd6, 32'd5});
        stepCheck(0, 0, 0, 16'h0, 0, "stop_idle");
        stepCheck(1, 1, 0, 16'h0, 5, "start_stop_idle");
        checkOutput("held_counts", {bus.STATE, bus.SYNC_LOST, bus.WORD_CNT, bus.ERR_CNT},
                    {3'd0, 1'b1, 32'd6, 32'd5});

        // Asynchronous reset in the middle of LOCKED
        runToLock(0);
        stepCheck(0, 0, 1, 16'h0001, 0, "pre_reset_1");
        stepCheck(0, 0, 1, 16'h0000, 0, "pre_reset_2");
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset", packActual(), 80'd0);
        modelReset();
        @(negedge CLK);
        RST_N = 1'b1;
        stepCheck(0, 0, 0, 16'h0, 0, "reset_release");

        // Sync timeout with valid gaps sprinkled in
        stepCheck(1, 0, 0, 16'h0, 0, "tmo_arm");
        stepCheck(0, 0, 0, 16'h0, 0, "tmo_sync");
        for (int k = 1; k <= SYNC_TMO; k++) begin
            if (k % 100 == 0) stepCheck(0, 0, 0, 16'h0001, 0, "tmo_gap");
            stepCheck(0, 0, 1, 16'h0001, 0, "tmo_word");
            if (k == SYNC_TMO - 1)
                checkOutput("tmo_before", {bus.STATE, bus.SYNC_FAIL}, {3'd2, 1'b0});
        end
        checkOutput("tmo_done", {bus.STATE, bus.DONE, bus.SYNC_FAIL, bus.WORD_CNT},
                    {3'd4, 1'b1, 1'b1, 32'd0});
        stepCheck(0, 0, 0, 16'h0, 0, "tmo_idle");

        // Saturation on the narrow-counter instance
        smallStep(1, 0, 0, 16'h0);
        smallStep(0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) smallStep(0, 0, 1, 16'h0);
        smallStep(0, 0, 1, 16'hFFFF);
        smallStep(0, 0, 1, 16'hFFFF);
        checkOutput("sat_err", {sbus.STATE, sbus.WORD_CNT, sbus.ERR_CNT}, {3'd3, 4'd2, 4'd15});
        for (int i = 0; i < 14; i++) smallStep(0, 0, 1, 16'h0);
        checkOutput("sat_word", {sbus.STATE, sbus.WORD_CNT, sbus.ERR_CNT}, {3'd3, 4'd15, 4'd15});
        smallStep(0, 1, 0, 16'h0);
        smallStep(0, 0, 0, 16'h0);
        checkModel("main_idle_during_sat");

        // Random traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      rvec = 16'h0000;
            else if (r < 8) rvec = 16'(1 << $urandom_range(0, 15));
            else if (r < 9) rvec = 16'(3 << $urandom_range(0, 14));
            else            rvec = 16'($urandom);
            stepCheck(($urandom % 8) == 0, ($urandom % 60) == 0, ($urandom % 4) != 0,
                      rvec, 32'($urandom_range(0, 13)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
